// File: rtl/aes8_pkg.sv
// Shared state encoding, block/timeout constants and byte-select helper for aes8_stream_host.
// ABORT exists only when AES8_TIMEOUT_EN is defined.
package aes8_pkg;
  localparam int AES_BLOCK_BYTES    = 16;
  localparam int AES_TIMEOUT_CYCLES = 512;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    LOAD,
    WAIT,
    COLLECT,
    FIN
`ifdef AES8_TIMEOUT_EN
    , ABORT
`endif
  } state_t;

  // Byte idx of a 128-bit word, byte 0 being bits [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] v, input logic [3:0] idx);
    logic [6:0] sh;
    sh = 7'd120 - {idx, 3'b000};
    return 8'(v >> sh);
  endfunction
endpackage

// File: rtl/aes8_stream_host.sv
// Streams key/plaintext MSB-first into a byte-serial AES core and reassembles the ciphertext; result_vld 33 cycles + core latency after start, start ignored while busy.
// AES8_TIMEOUT_EN: WAIT is bounded by TIMEOUT_CYCLES and aborts with a one-cycle err pulse; otherwise WAIT is unbounded and err is tied low.
module aes8_stream_host
  import aes8_pkg::*;
#(
  parameter int BLOCK_BYTES    = AES_BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = AES_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_i,
  input  logic [127:0] pt_i,
  output logic         busy,
  output logic [127:0] result_o,
  output logic         result_vld,
  output logic         core_rst,
  output logic [7:0]   core_key,
  output logic [7:0]   core_din,
  input  logic [7:0]   core_dout,
  input  logic         core_dvld,
  output logic         err
);

  localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);

  if (BLOCK_BYTES != AES_BLOCK_BYTES) begin : g_chk_bytes
    $error("BLOCK_BYTES must be 16: the datapath is a fixed 128-bit block");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t       r_state;
  logic [127:0] r_key;
  logic [127:0] r_pt;
  logic [119:0] r_acc;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 4'd1;

`ifdef AES8_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_pt       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      result_o   <= '0;
      result_vld <= 1'b0;
      core_rst   <= 1'b1;
      core_key   <= 8'h00;
      core_din   <= 8'h00;
`ifdef AES8_TIMEOUT_EN
      r_tmo      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      result_vld <= 1'b0;
`ifdef AES8_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          core_rst <= 1'b1;
          if (start) begin
            r_key   <= key_i;
            r_pt    <= pt_i;
            busy    <= 1'b1;
            r_state <= CRST;
          end
        end
        CRST: begin
          core_rst <= 1'b0;
          core_key <= get_byte(r_key, 4'd0);
          core_din <= get_byte(r_pt, 4'd0);
          r_cnt    <= 4'd0;
          r_state  <= LOAD;
        end
        LOAD: begin
          if (r_cnt == LAST_IDX) begin
            core_key <= 8'h00;
            core_din <= 8'h00;
            r_cnt    <= 4'd0;
`ifdef AES8_TIMEOUT_EN
            r_tmo    <= '0;
`endif
            r_state  <= WAIT;
          end else begin
            core_key <= get_byte(r_key, w_cnt_nxt);
            core_din <= get_byte(r_pt, w_cnt_nxt);
            r_cnt    <= w_cnt_nxt;
          end
        end
        WAIT: begin
          // core_dvld only gates entry; the core then streams 16 bytes back-to-back
          if (core_dvld) begin
            r_acc   <= {r_acc[111:0], core_dout};
            r_cnt   <= 4'd1;
            r_state <= COLLECT;
          end
`ifdef AES8_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_err    <= 1'b1;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            r_state  <= ABORT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end
        COLLECT: begin
          if (r_cnt == LAST_IDX) begin
            result_o   <= {r_acc, core_dout};
            result_vld <= 1'b1;
            busy       <= 1'b0;
            core_rst   <= 1'b1;
            r_cnt      <= 4'd0;
            r_state    <= FIN;
          end else begin
            r_acc <= {r_acc[111:0], core_dout};
            r_cnt <= w_cnt_nxt;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
`ifdef AES8_TIMEOUT_EN
        ABORT: begin
          r_state <= IDLE;
        end
`endif
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes8_stream_host.md
AES8_STREAM_HOST -- requirements
Module: aes8_stream_host

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 16, the number of bytes per AES block streamed to and from the core.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 512, the maximum number of WAIT cycles before an abort (only when AES8_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to encrypt pt_i under key_i.
REQ-006 SHALL have ports key_i and pt_i, input, 128 bits each: key and plaintext, sampled on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high from an accepted start until result_vld or err is issued.
REQ-008 SHALL have port result_o, output, 128 bits: assembled ciphertext.
REQ-009 SHALL have port result_vld, output, 1 bit: one-cycle pulse marking result_o valid.
REQ-010 SHALL have port core_rst, output, 1 bit: active-high reset to the byte-serial AES core.
REQ-011 SHALL have ports core_key and core_din, output, 8 bits each: key and data bytes to the core.
REQ-012 SHALL have port core_dout, input, 8 bits: ciphertext byte from the core.
REQ-013 SHALL have port core_dvld, input, 1 bit: core output-valid flag.
REQ-014 SHALL have port err, output, 1 bit: timeout abort pulse (only when AES8_TIMEOUT_EN is defined; otherwise tied 0).

Function
REQ-015 SHALL use the states IDLE, CRST, LOAD, WAIT, COLLECT and FIN (plus ABORT under AES8_TIMEOUT_EN).
REQ-016 SHALL in IDLE accept start: latch key_i and pt_i, set busy, and go to CRST.
REQ-017 SHALL ignore start in all states other than IDLE; the latched operands SHALL NOT change.
REQ-018 SHALL in CRST drive core_rst=1 for exactly 1 cycle, then go to LOAD.
REQ-019 SHALL in LOAD drive core_rst=0 and present byte k (k=0..15) on core_key/core_din in LOAD cycle k, MSB first (byte 0 = bits [127:120]), then go to WAIT after 16 cycles.
REQ-020 SHALL in WAIT hold core_key and core_din at 0 and go to COLLECT on the first cycle with core_dvld=1; that cycle's core_dout is captured as byte 0.
REQ-021 SHALL in COLLECT capture core_dout into result bits [127-8j -: 8] for j=1..15 on consecutive cycles, regardless of core_dvld.
REQ-022 SHALL after the 16th byte enter FIN, update result_o, and pulse result_vld for 1 cycle with busy dropping in the same cycle, then return to IDLE.
REQ-023 SHALL hold result_o stable until the next result_vld.
REQ-024 SHALL keep core_rst=1 in IDLE so the core is quiescent between blocks.
REQ-025 SHALL count byte indices with a 4-bit counter that wraps 15->0 at each LOAD/COLLECT exit.
REQ-026 SHALL require core_dvld only at entry to COLLECT; a later deassertion of core_dvld SHALL NOT stall COLLECT.
REQ-027 SHALL accept a start presented in the cycle after result_vld and begin a new block.

Reset
REQ-028 SHALL on rst=0, at any time including mid-block, force: state IDLE, busy 0, result_vld 0, err 0, result_o 0, core_rst 1, core_key 0, core_din 0, counters 0.
REQ-029 SHALL resume from IDLE after reset release; the interrupted block is discarded with no result_vld.

Configuration
REQ-030 SHALL, when AES8_TIMEOUT_EN is defined, count WAIT cycles and, on reaching TIMEOUT_CYCLES, enter ABORT: pulse err for 1 cycle, assert core_rst, clear busy, return to IDLE, and leave result_o unchanged.
REQ-031 SHALL, when AES8_TIMEOUT_EN is undefined, omit the timeout counter and the ABORT state, tie err to 0, and wait in WAIT indefinitely.

Structure
REQ-032 SHALL place the state enum, AES_BLOCK_BYTES=16 and the default TIMEOUT_CYCLES in the shared package aes8_pkg.
REQ-033 SHALL implement the design as a single module; the optional sub-module aes8_byte_shifter (128-bit parallel-to-byte and byte-to-parallel shift register) MAY be factored out.

Verification
REQ-034 SHALL check the FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, start -> result_o 69c4e0d86a7b0430d8cdb78070b4c55a with a single result_vld pulse.
REQ-035 SHALL check LOAD ordering: in LOAD cycle 0 core_din=0x00 and core_key=0x00; in cycle 15 core_din=0xff and core_key=0x0f; core_rst is high for exactly 1 cycle beforehand.
REQ-036 SHALL check that a start pulse while busy is ignored: the result equals the first vector and there is no second result_vld.
REQ-037 SHALL check rst=0 during COLLECT byte 7: outputs go to reset values immediately, and no result_vld follows.
REQ-038 SHALL check that with the core model never asserting core_dvld and AES8_TIMEOUT_EN defined, err pulses after 512 WAIT cycles and busy=0.
REQ-039 SHALL check back-to-back blocks with start in the cycle after result_vld: both ciphertexts are correct, with 2 result_vld pulses.
